// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: memory-side bus of the copy engine.
// master drives address, write data and strobes; slave returns read data.
interface mem_copy_engine_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_access_addr,
    output mem_write_data,
    output mem_write_en,
    output mem_read,
    input  mem_read_data
  );

  modport slave (
    input  mem_access_addr,
    input  mem_write_data,
    input  mem_write_en,
    input  mem_read,
    output mem_read_data
  );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-by-word forward block copy master for the data memory.
// Define MEMCPY_VERIFY_EN to read back each written word and flag mismatches.
module mem_copy_engine #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic              verify_err,
  mem_copy_engine_if.master mem
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
`ifdef MEMCPY_VERIFY_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  rem;

`ifdef MEMCPY_VERIFY_EN
  logic [DATA_W-1:0] data_buf;
  logic              err_q;
  assign verify_err = err_q;
`else
  assign verify_err = 1'b0;
`endif

  // Outputs are registered for the state being entered, so the
  // memory never sees a combinational path from start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      src_ptr             <= '0;
      dst_ptr             <= '0;
      rem                 <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      words_done          <= '0;
      mem.mem_access_addr <= '0;
      mem.mem_write_data  <= '0;
      mem.mem_write_en    <= 1'b0;
      mem.mem_read        <= 1'b0;
`ifdef MEMCPY_VERIFY_EN
      data_buf            <= '0;
      err_q               <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            src_ptr    <= src_addr;
            dst_ptr    <= dst_addr;
            rem        <= len;
            words_done <= '0;
`ifdef MEMCPY_VERIFY_EN
            err_q      <= 1'b0;
`endif
            if (len != '0) begin
              state               <= READ;
              busy                <= 1'b1;
              mem.mem_read        <= 1'b1;
              mem.mem_access_addr <= src_addr;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          state               <= WRITE;
          mem.mem_read        <= 1'b0;
          mem.mem_write_en    <= 1'b1;
          mem.mem_access_addr <= dst_ptr;
          mem.mem_write_data  <= mem.mem_read_data;
`ifdef MEMCPY_VERIFY_EN
          data_buf            <= mem.mem_read_data;
`endif
        end
        WRITE: begin
`ifdef MEMCPY_VERIFY_EN
          state              <= CHECK;
          mem.mem_write_en   <= 1'b0;
          mem.mem_read       <= 1'b1;
          mem.mem_write_data <= '0;
        end
        CHECK: begin
          if (mem.mem_read_data != data_buf) err_q <= 1'b1;
`endif
          src_ptr            <= src_ptr + ADDR_W'(1);
          dst_ptr            <= dst_ptr + ADDR_W'(1);
          rem                <= rem - LEN_W'(1);
          words_done         <= words_done + LEN_W'(1);
          mem.mem_write_en   <= 1'b0;
          mem.mem_write_data <= '0;
          if (rem == LEN_W'(1)) begin
            state               <= DONE;
            busy                <= 1'b0;
            done                <= 1'b1;
            mem.mem_read        <= 1'b0;
            mem.mem_access_addr <= '0;
          end else begin
            state               <= READ;
            mem.mem_read        <= 1'b1;
            mem.mem_access_addr <= src_ptr + ADDR_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed copies checked cycle by cycle against
// a forward word-copy model of the memory and the access sequence.
module tb_mem_copy_engine;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 4;
`ifdef MEMCPY_VERIFY_EN
  localparam int PER = 3;
`else
  localparam int PER = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          done;
  logic          verify_err;
  logic [LW-1:0] words_done;

  mem_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .verify_err (verify_err),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] pre_mem [8];
  logic          pre_ld = 1'b0;
  logic [DW-1:0] stuck = '0;

  assign bus.mem_read_data = mem[bus.mem_access_addr[2:0]];

  always @(posedge clk) begin
    if (pre_ld) mem <= pre_mem;
    else if (bus.mem_write_en)
      mem[bus.mem_access_addr[2:0]] <= bus.mem_write_data | stuck;
  end

  int n_pass = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model state for the copy in flight
  bit            chk_on = 1'b0;
  int            cyc;
  int            done_cyc;
  int            m_len;
  int            w;
  int            ph;
  logic [AW-1:0] m_src;
  logic [AW-1:0] m_dst;
  logic [DW-1:0] exp_mem [8];
  logic [DW-1:0] last_d;
  logic          err_exp;

  always @(negedge clk) begin
    if (chk_on) begin
      cyc++;
      chk("verify_err", verify_err, err_exp);
      if (cyc == PER * m_len + 1) begin
        done_cyc = cyc;
        chk("done_ctl", {busy, done, bus.mem_read, bus.mem_write_en}, 4'b0100);
        chk("done_bus", {bus.mem_access_addr, bus.mem_write_data}, '0);
        chk("done_words", words_done, LW'(m_len));
        chk_on = 1'b0;
      end else begin
        w  = (cyc - 1) / PER;
        ph = (cyc - 1) % PER;
        chk("words", words_done, LW'(w));
        if (ph == 0) begin
          chk("rd_ctl", {busy, done, bus.mem_read, bus.mem_write_en}, 4'b1010);
          chk("rd_addr", bus.mem_access_addr, m_src + AW'(w));
        end else if (ph == 1) begin
          last_d = exp_mem[3'(m_src + AW'(w))];
          chk("wr_ctl", {busy, done, bus.mem_read, bus.mem_write_en}, 4'b1001);
          chk("wr_addr", bus.mem_access_addr, m_dst + AW'(w));
          chk("wr_data", bus.mem_write_data, last_d);
          exp_mem[3'(m_dst + AW'(w))] = last_d | stuck;
        end else begin
          chk("ck_ctl", {busy, done, bus.mem_read, bus.mem_write_en}, 4'b1010);
          chk("ck_addr", bus.mem_access_addr, m_dst + AW'(w));
          if (exp_mem[3'(m_dst + AW'(w))] != last_d) err_exp = 1'b1;
        end
      end
    end
  end

  task automatic preload();
    @(negedge clk);
    for (int i = 0; i < 8; i++) pre_mem[i] = DW'(64'h11 * (i + 1));
    pre_ld = 1'b1;
    @(posedge clk);
    #1 pre_ld = 1'b0;
  endtask

  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input int l, input bit glitch);
    int t;
    @(negedge clk);
    for (int i = 0; i < 8; i++) exp_mem[i] = mem[i];
    m_src = s; m_dst = d; m_len = l;
    cyc = 0; done_cyc = -1; err_exp = 1'b0;
    src_addr = s; dst_addr = d; len = LW'(l); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; src_addr = '1; dst_addr = '1; len = '1;
    chk_on = 1'b1;
    if (glitch) begin
      @(posedge clk);
      #1;
      start = 1'b1; src_addr = AW'(5); dst_addr = AW'(6); len = LW'(2);
      @(posedge clk);
      #1 start = 1'b0;
    end
    t = 0;
    while (chk_on && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (chk_on) begin
      chk("timeout", 1'b1, 1'b0);
      chk_on = 1'b0;
    end
    @(negedge clk);
    chk("post_ctl", {busy, done, bus.mem_read, bus.mem_write_en}, 4'b0000);
    chk("post_words", words_done, LW'(l));
    chk("post_verr", verify_err, err_exp);
    for (int i = 0; i < 8; i++) chk("mem_model", mem[i], exp_mem[i]);
  endtask

  initial begin
    #2;
    chk("rst_ctl", {busy, done, bus.mem_read, bus.mem_write_en, verify_err}, 5'b0);
    chk("rst_bus", {bus.mem_access_addr, bus.mem_write_data}, '0);
    chk("rst_words", words_done, '0);
    @(negedge clk);
    rst_n = 1'b1;

    preload();
    run_copy(AW'(0), AW'(4), 3, 1'b0);
    chk("t1_mem4", mem[4], 64'h11);
    chk("t1_mem5", mem[5], 64'h22);
    chk("t1_mem6", mem[6], 64'h33);
    chk("t1_words", words_done, 4'd3);
`ifdef MEMCPY_VERIFY_EN
    chk("t1_done_cyc", done_cyc, 10);
`else
    chk("t1_done_cyc", done_cyc, 7);
`endif

    preload();
    run_copy(AW'(2), AW'(5), 0, 1'b0);
    chk("t2_done_cyc", done_cyc, 1);
    chk("t2_mem5", mem[5], 64'h66);

    preload();
    run_copy(AW'(6), AW'(0), 4, 1'b0);
    chk("t3_mem0", mem[0], 64'h77);
    chk("t3_mem1", mem[1], 64'h88);
    chk("t3_mem2", mem[2], 64'h77);
    chk("t3_mem3", mem[3], 64'h88);

    preload();
    run_copy(AW'(0), AW'(1), 3, 1'b1);
    chk("t4_mem1", mem[1], 64'h11);
    chk("t4_mem2", mem[2], 64'h11);
    chk("t4_mem3", mem[3], 64'h11);
    chk("t4_mem4", mem[4], 64'h55);

    // Abort in the first WRITE cycle
    preload();
    @(negedge clk);
    src_addr = AW'(0); dst_addr = AW'(4); len = LW'(3); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2;
    chk("ab_pre_we", bus.mem_write_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ab_ctl", {busy, done, bus.mem_read, bus.mem_write_en}, 4'b0000);
    chk("ab_bus", {bus.mem_access_addr, bus.mem_write_data}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ab_idle", {busy, done, bus.mem_read, bus.mem_write_en}, 4'b0000);
    end
    chk("ab_mem4", mem[4], 64'h55);

`ifdef MEMCPY_VERIFY_EN
    stuck = 64'h100;
    preload();
    run_copy(AW'(0), AW'(4), 2, 1'b0);
    chk("v_err_set", verify_err, 1'b1);
    chk("v_mem4", mem[4], 64'h111);
    stuck = '0;
    preload();
    run_copy(AW'(1), AW'(5), 2, 1'b0);
    chk("v_err_clr", verify_err, 1'b0);
    chk("v_done_cyc", done_cyc, 7);
`else
    chk("verr_tied", verify_err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side block for the 8-word, 64-bit data memory. It owns the memory's address, write-data, write-enable and read-enable inputs.
- It copies a block of `len` words from `src_addr` to `dst_addr`, one word at a time, using a Moore FSM: read the word, then write it.
- It sits between the datapath control (or testbench) and the data memory. It gives the memory a second master for block moves.

Parameters:
- ADDR_W, 64: width of the memory address bus and of the address pointers.
- DATA_W, 64: width of the memory data bus and of the copy buffer.
- LEN_W, 4: width of the `len` input and `words_done` output; supports 0..15 words.

Ports:
- clk  in  1  rising-edge clock, shared with the data memory
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a copy; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address
- dst_addr  in  ADDR_W  first destination word address
- len  in  LEN_W  number of words to copy
- busy  out  1  high in READ, WRITE and CHECK states
- done  out  1  one-cycle pulse when the copy finishes
- words_done  out  LEN_W  words written so far in the current copy
- verify_err  out  1  sticky read-back mismatch flag
- mem_access_addr  out  ADDR_W  address to the memory
- mem_write_data  out  DATA_W  write data to the memory
- mem_write_en  out  1  memory write strobe; the memory writes on the clk edge
- mem_read  out  1  memory read enable
- mem_read_data  in  DATA_W  combinational read data from the memory

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, mem_write_en and mem_read are 0.
  - words_done, verify_err, mem_access_addr, mem_write_data, internal pointers and the buffer are 0.
  - Reset mid-copy aborts immediately. No further memory strobes occur and no done pulse is produced.
- States: IDLE, READ, WRITE, CHECK (only with the optional feature), DONE.
- All memory outputs are decoded from state and registered pointers. Memory outputs never depend combinationally on `start`.
- IDLE:
  - All strobes are 0.
  - start=1 latches src_ptr=src_addr, dst_ptr=dst_addr, rem=len; clears words_done and verify_err.
  - Next state is READ if len!=0, otherwise DONE. A zero-length copy produces no memory access.
- READ:
  - mem_read=1, mem_access_addr=src_ptr, mem_write_en=0.
  - On the next edge: buf<=mem_read_data; go to WRITE.
- WRITE:
  - mem_write_en=1, mem_access_addr=dst_ptr, mem_write_data=buf, mem_read=0.
  - On the next edge: src_ptr+=1, dst_ptr+=1, rem-=1, words_done+=1.
  - Next state is DONE if rem==1, otherwise READ.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. words_done holds its value until the next start.
- start is ignored in READ, WRITE, CHECK and DONE. It is not queued.
- mem_read and mem_write_en are never high in the same cycle. Outside READ, WRITE and CHECK, mem_access_addr and mem_write_data are 0.
- Pointer arithmetic is unsigned, modulo 2^ADDR_W. The memory decodes only addr[2:0], so copies wrap 7->0 naturally.
- Overlap: the copy is strictly forward and word by word. If dst lies inside (src, src+len), previously written words are re-read. This propagation is the defined behaviour; no overlap correction is done.
- Latency without the feature: done is high in cycle 2*len+1 after the start edge (cycle 1 for len=0).

Optional Feature:
- Macro: MEMCPY_VERIFY_EN.
- When defined:
  - WRITE goes to CHECK instead of advancing the pointers and counters.
  - CHECK drives mem_read=1, mem_access_addr=dst_ptr, mem_write_en=0.
  - On the next edge, if mem_read_data!=buf then verify_err<=1 (sticky until the next accepted start).
  - CHECK then performs the pointer, rem and words_done updates and the DONE/READ decision that WRITE performs without the feature.
  - Each word takes 3 cycles; done arrives in cycle 3*len+1.
- When not defined: there is no CHECK state and verify_err is tied to 0.

Test Plan:
- Memory preloaded with mem[i]=0x11*(i+1). start, src=0, dst=4, len=3 -> mem[4..6]=0x11,0x22,0x33; done pulses once in cycle 7; words_done=3; read and write strobes strictly alternate.
- len=0, src=2, dst=5 -> done in cycle 1; no mem_read or mem_write_en pulse; memory unchanged.
- Wrap: src=6, dst=0, len=4 -> mem[0..3]=old mem[6],mem[7],mem[0],mem[1] under forward semantics; address outputs show 6,0,7,1,8,2,9,3 in ADDR_W arithmetic.
- Overlap: preload 0x11..0x88, src=0, dst=1, len=3 -> mem[1..3]=0x11,0x11,0x11.
- start pulsed again in cycle 2 of an active copy -> ignored; rst_n dropped in a WRITE cycle -> strobes go to 0 in the same cycle, state is IDLE, no done pulse.
- With MEMCPY_VERIFY_EN: force a stuck bit on memory write data -> verify_err=1 after the first CHECK and remains set; a clean copy gives verify_err=0 and done in cycle 3*len+1.
